// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with conditional branches, call/return stack, stall and sticky halt
module pc_sequencer #(
  parameter int PC_W = 16,
  parameter int IMM_W = 9,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_ins,
  input  logic             branch_type,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic [2:0]       C,
  input  logic [2:0]       F,
  input  logic [IMM_W-1:0] I,
  input  logic [PC_W-1:0]  reg2_data,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             taken,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, target, ras_top;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] sp_q, sp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, push, pop, cond;
  logic [7:0] cond_v;
  assign pc = pc_q;
  assign pc_plus2 = pc_q + PC_W'(2);
  assign halted = state_q == HALTED;
  assign ras_empty = cnt_q == '0;
  assign ras_full = cnt_q == FULL;
  assign ras_err = err_q;
  assign ras_top = ras_q[sp_q - 1'b1];
  assign target = branch_type ? reg2_data : pc_plus2 + (PC_W'($signed(I)) << 1);
  assign cond_v = {1'b1, F[1], F[0] | F[2], F[0] | !F[2], F[2], !F[0] & !F[2], F[0], !F[0]};
  assign cond = cond_v[C];
  assign taken = !halted && !halt && (ret ? !ras_empty : call || (branch_ins && cond));
  // next PC, halt transition and stack push/pop decision by priority
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    push = 1'b0;
    pop = 1'b0;
    err_d = 1'b0;
    if (state_q == RUN && !stall) begin
      if (halt) state_d = HALTED;
      else if (ret) begin
        pop = !ras_empty;
        pc_d = ras_empty ? pc_plus2 : ras_top;
        err_d = ras_empty || call;
      end else if (call) begin
        push = 1'b1;
        pc_d = target;
      end else pc_d = (branch_ins && cond) ? target : pc_plus2;
    end
    sp_d = push ? sp_q + 1'b1 : pop ? sp_q - 1'b1 : sp_q;
    cnt_d = push ? (ras_full ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      sp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // stack storage; a push when full overwrites the oldest slot at sp
  always_ff @(posedge clk) begin
    if (push && !rst) ras_q[sp_q] <= pc_plus2;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the fetch stage; the successor to the combinational next-PC logic, parametrised in PC/immediate width. Owns the PC register and evaluates conditional branches (immediate or register target) against the ALU flags. Also handles stall, a sticky halt state, and a parametrised return-address stack (RAS) for call/return. Drives the instruction-memory address and the PC+2 value consumed by decode.

## Interface

- PC_W, 16, PC and data width (even, ≥ 8)
- IMM_W, 9, branch immediate width (signed, word offset)
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥ 2)
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and RAS this cycle
- branch_ins  in  1  current instruction is a conditional branch
- branch_type  in  1  0 = immediate target, 1 = register target
- call  in  1  unconditional call: push PC+2, jump to target
- ret  in  1  return: pop RAS, jump to popped address
- halt  in  1  current instruction is HLT
- C  in  3  condition code
- F  in  3  flags {N, V, Z}
- I  in  IMM_W  signed branch offset in words
- reg2_data  in  PC_W  register branch/call target
- pc  out  PC_W  current PC (registered)
- pc_plus2  out  PC_W  pc + 2, combinational
- taken  out  1  combinational: next PC ≠ pc_plus2 due to branch/call/ret
- halted  out  1  registered halt state
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_err  out  1  one-cycle registered pulse on RAS misuse

## Operation

- Target: branch_type=0 → pc_plus2 + (sext(I) << 1), mod 2^PC_W; branch_type=1 → reg2_data.
- Conditions on C: 000 NE (Z=0), 001 EQ (Z=1), 010 GT (Z=0 & N=0), 011 LT (N=1), 100 GE (Z=1 | N=0), 101 LE (Z=1 | N=1), 110 OV (V=1), 111 always.
- States: RUN, HALTED. Reset → RUN. RUN with halt=1 and stall=0 → HALTED. HALTED exits only on rst.
- Next-PC priority, highest first:
  1. rst → RESET_PC.
  2. HALTED or stall → hold pc.
  3. halt → hold pc; go to HALTED.
  4. ret → RAS top (pop); if RAS empty → pc_plus2 and ras_err.
  5. call → target; push pc_plus2.
  6. branch_ins & condition true → target.
  7. Otherwise → pc_plus2.
- call and ret together: ret wins, call ignored, ras_err pulses.
- RAS is circular. Push when full overwrites the oldest entry, count stays RAS_DEPTH, no error. Pop when empty changes nothing.
- Stall or halt suppresses all RAS pushes/pops and ras_err.
- taken and the target path are combinational; they are valid whenever inputs are stable, including during stall.

## Timing

- Reset values: pc=RESET_PC, halted=0, ras_empty=1, ras_full=0, ras_err=0; RAS count 0 (contents don't-care).
- pc updates one cycle after inputs are sampled (single-cycle next-PC latency).
- halted asserts the cycle after halt is sampled; pc is frozen from then on.
- ras_err is high exactly the cycle after the offending edge.
- rst mid-operation (any state, any RAS fill): all outputs take reset values on the next edge.

## Test plan

- Reset, then 3 free-running cycles → pc = 0, 2, 4, 6; taken=0.
- pc=10, branch_ins=1, C=111, I=−2, branch_type=0 → pc=8 next cycle. Same with C=001, F=000 → pc=12.
- call with branch_type=1, reg2_data=1000, at pc=10 → pc=1000, ras_empty=0. Later ret → pc=12.
- 5 calls with RAS_DEPTH=4, then 5 rets: first 4 rets return to the 2nd–5th push addresses (newest first); 5th ret → pc_plus2 and a one-cycle ras_err.
- stall=1 with branch_ins=1, C=111 for 3 cycles → pc and RAS unchanged, taken=1; release → branch taken.
- halt at pc=100 → halted=1, pc stays 100 for 10 cycles despite branch/call; rst → pc=0, halted=0.
